// File: rtl/output_limit_ctrl.sv
// -----------------------------------------------------------------------------
// output_limit_ctrl
//
// Purpose:
//   Sits on IFCLK between the upstream output FIFO (first-word-fall-through
//   read port) and the high-speed I/O block. Every data word passes through a
//   2-entry prefetch buffer, so dout comes straight from a register. In limit
//   mode the host latches a word budget with a one-cycle pulse, and the block
//   releases exactly that many words downstream. In pass-all mode every
//   buffered word is released.
//
// Ports:
//   CLK                    in   IFCLK domain clock
//   RST                    in   synchronous, active-high reset
//   up_dout                in   upstream FWFT head word (valid when !up_empty)
//   up_empty               in   upstream FIFO empty
//   up_count               in   upstream occupancy in words
//   up_rd_en               out  consume the upstream head word this cycle
//   dout                   out  registered head word presented downstream
//   empty                  out  no word may be released downstream
//   rd_en                  in   downstream consumes dout this cycle
//   mode_limit             in   1 = limit mode, 0 = pass-all
//   reg_output_limit       in   one-cycle pulse: latch a new limit
//   output_limit           out  last latched limit, in words
//   output_limit_not_done  out  latched limit not yet fully sent
// -----------------------------------------------------------------------------
module output_limit_ctrl #(
  parameter int WORD_W     = 16,
  parameter int LIMIT_W    = 16,
  parameter int UP_COUNT_W = 13
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WORD_W-1:0]     up_dout,
  input  logic                  up_empty,
  input  logic [UP_COUNT_W-1:0] up_count,
  output logic                  up_rd_en,
  output logic [WORD_W-1:0]     dout,
  output logic                  empty,
  input  logic                  rd_en,
  input  logic                  mode_limit,
  input  logic                  reg_output_limit,
  output logic [LIMIT_W-1:0]    output_limit,
  output logic                  output_limit_not_done
);

  // avail needs one extra bit: full upstream FIFO plus two buffered words
  localparam int AVAIL_W = UP_COUNT_W + 1;
  // common width used to compare avail against the largest representable limit
  localparam int WIDE_W  = (AVAIL_W > LIMIT_W) ? AVAIL_W : LIMIT_W;

  // Clamp a word count to the largest value the limit register can hold.
  function automatic logic [LIMIT_W-1:0] sat_to_limit(input logic [WIDE_W-1:0] value);
    logic [WIDE_W-1:0]  max_value;
    logic [LIMIT_W-1:0] result;
    max_value = WIDE_W'({LIMIT_W{1'b1}});
    if (value > max_value) begin
      result = {LIMIT_W{1'b1}};
    end else begin
      result = value[LIMIT_W-1:0];
    end
    return result;
  endfunction

  logic [WORD_W-1:0]  head_r;
  logic [WORD_W-1:0]  tail_r;
  logic [1:0]         buf_cnt_r;
  logic [LIMIT_W-1:0] remaining_r;
  logic [LIMIT_W-1:0] output_limit_r;
  logic               not_done_r;

  logic               empty_s;
  logic               pop_s;
  logic               push_s;
  logic [AVAIL_W-1:0] avail_s;
  logic [LIMIT_W-1:0] latch_val_s;
  logic [LIMIT_W-1:0] remaining_next_s;
  logic [LIMIT_W-1:0] output_limit_next_s;

  // Release/consume handshakes and the word count available for a new limit.
  always_comb begin
    empty_s = (buf_cnt_r == 2'd0) | (mode_limit & (remaining_r == {LIMIT_W{1'b0}}));
    pop_s   = rd_en & ~empty_s;
    // Reset is folded in so nothing is pulled from upstream while it is held.
    push_s  = ~RST & ~up_empty & ((buf_cnt_r < 2'd2) | pop_s);
    avail_s = {1'b0, up_count} + {{(AVAIL_W-2){1'b0}}, buf_cnt_r};
    latch_val_s = sat_to_limit(WIDE_W'(avail_s));
  end

  // Next value of the word budget and of the reported limit.
  always_comb begin
    remaining_next_s    = remaining_r;
    output_limit_next_s = output_limit_r;
    if (!mode_limit) begin
      // pass-all: the budget is dropped, the reported limit is kept
      remaining_next_s = {LIMIT_W{1'b0}};
    end else if (pop_s) begin
      // a pop implies remaining_r != 0, so any simultaneous pulse is ignored
      remaining_next_s = remaining_r - {{(LIMIT_W-1){1'b0}}, 1'b1};
    end else if (reg_output_limit && (remaining_r == {LIMIT_W{1'b0}})) begin
      remaining_next_s    = latch_val_s;
      output_limit_next_s = latch_val_s;
    end else begin
      remaining_next_s    = remaining_r;
      output_limit_next_s = output_limit_r;
    end
  end

  // Two-entry prefetch buffer; head_r drives dout directly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_r    <= {WORD_W{1'b0}};
      tail_r    <= {WORD_W{1'b0}};
      buf_cnt_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (buf_cnt_r == 2'd0) begin
            head_r <= up_dout;
          end else begin
            tail_r <= up_dout;
          end
          buf_cnt_r <= buf_cnt_r + 2'd1;
        end
        2'b01: begin
          head_r    <= tail_r;
          buf_cnt_r <= buf_cnt_r - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the incoming word goes behind the survivor
          if (buf_cnt_r == 2'd1) begin
            head_r <= up_dout;
          end else begin
            head_r <= tail_r;
            tail_r <= up_dout;
          end
        end
        default: begin
          buf_cnt_r <= buf_cnt_r;
        end
      endcase
    end
  end

  // Limit state registers; not_done tracks the next budget so it moves with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      remaining_r    <= {LIMIT_W{1'b0}};
      output_limit_r <= {LIMIT_W{1'b0}};
      not_done_r     <= 1'b0;
    end else begin
      remaining_r    <= remaining_next_s;
      output_limit_r <= output_limit_next_s;
      not_done_r     <= (remaining_next_s != {LIMIT_W{1'b0}});
    end
  end

  assign dout                  = head_r;
  assign empty                 = empty_s;
  assign up_rd_en              = push_s;
  assign output_limit          = output_limit_r;
  assign output_limit_not_done = not_done_r;

endmodule
